// File: rtl/lattice_fitness_engine.sv
// Fitness evaluator for lattice-particle individuals: streams in energy tables,
// scores each individual site by site and tracks the population's best member.
module lattice_fitness_engine #(
    parameter int INT8_LENGTH       = 8,
    parameter int ENERGY_LENGTH     = 4,
    parameter int PARTICLE_LENGTH   = 2,
    parameter int LATTICE_LENGTH    = 11,
    parameter int INDIVIDUAL_LENGTH = PARTICLE_LENGTH * LATTICE_LENGTH,
    parameter int IND_FIT_LENGTH    = 10,
    parameter int NUM_PARTICLE_TYPE = 3,
    parameter int PERIODIC          = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_self,
    input  logic [ENERGY_LENGTH-1:0]     self_energy_in,
    input  logic                         in_valid_interact,
    input  logic [ENERGY_LENGTH-1:0]     interact_energy_in,
    input  logic                         in_valid_ind,
    input  logic [INDIVIDUAL_LENGTH-1:0] ind_state_in,
    input  logic [INT8_LENGTH-1:0]       ind_mut_in,
    input  logic                         ind_last_in,
    output logic                         in_ready,
    output logic                         fit_valid,
    output logic [IND_FIT_LENGTH-1:0]    fit_o,
    output logic                         fit_invalid_o,
    output logic                         best_valid,
    output logic [IND_FIT_LENGTH-1:0]    Min_fit_o,
    output logic [INDIVIDUAL_LENGTH-1:0] Best_ind_state_o,
    output logic [INT8_LENGTH-1:0]       Best_ind_mut_o
);

    localparam int N   = NUM_PARTICLE_TYPE;
    localparam int NN  = N * N;
    localparam int PL  = PARTICLE_LENGTH;
    localparam int PL1 = PL + 1;
    localparam int FW  = IND_FIT_LENGTH;
    localparam int EW  = ENERGY_LENGTH;
    localparam int SW  = (N > 1) ? $clog2(N) : 1;
    localparam int IW  = (NN > 1) ? $clog2(NN) : 1;
    localparam int KW  = (LATTICE_LENGTH > 1) ? $clog2(LATTICE_LENGTH) : 1;

    localparam logic [PL:0]   N_EXT  = PL1'(NUM_PARTICLE_TYPE);
    localparam logic [SW-1:0] S_LAST = SW'(N - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NN - 1);
    localparam logic [KW-1:0] K_LAST = KW'(LATTICE_LENGTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_BEST = 2'd3;

    logic [EW-1:0] self_tab  [N];
    logic [EW-1:0] inter_tab [NN];

    logic [SW-1:0] ptr_s;
    logic [IW-1:0] ptr_i;
    logic          self_loaded;
    logic          inter_loaded;

    logic [1:0]                   fsm_state;
    logic [KW-1:0]                k;
    logic [FW-1:0]                acc;
    logic                         invalid;
    logic [INDIVIDUAL_LENGTH-1:0] shift_reg;
    logic [PL-1:0]                first_code;
    logic [INDIVIDUAL_LENGTH-1:0] ind_state;
    logic [INT8_LENGTH-1:0]       ind_mut;
    logic                         ind_last;

    logic                         best_held;
    logic [FW-1:0]                best_fit;
    logic [INDIVIDUAL_LENGTH-1:0] best_state;
    logic [INT8_LENGTH-1:0]       best_mut;

    logic [PL-1:0] cur_code;
    logic [PL-1:0] nxt_code;
    logic          cur_ok;
    logic          nxt_ok;
    logic          has_bond;
    logic [SW-1:0] safe_cur;
    logic [SW-1:0] safe_nxt;
    logic [IW-1:0] inter_idx;
    logic [EW-1:0] self_e;
    logic [EW-1:0] bond_e;
    logic [EW:0]   step;
    logic [FW:0]   sum;
    logic [FW-1:0] acc_next;
    logic [FW-1:0] final_fit;
    logic          accept;

    // The flag that gates in_ready during a best_valid pulse keeps a new
    // population from starting while the previous best is being reported.
    assign in_ready = (fsm_state == S_IDLE) && self_loaded && inter_loaded && !best_valid;
    assign accept   = in_valid_ind && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_s       <= '0;
            self_loaded <= 1'b0;
        end else if (in_valid_self) begin
            if (ptr_s == '0) begin
                self_loaded <= 1'b0;
            end
            if (ptr_s == S_LAST) begin
                ptr_s       <= '0;
                self_loaded <= 1'b1;
            end else begin
                ptr_s <= ptr_s + 1'b1;
            end
        end else begin
            ptr_s <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_i        <= '0;
            inter_loaded <= 1'b0;
        end else if (in_valid_interact) begin
            if (ptr_i == '0) begin
                inter_loaded <= 1'b0;
            end
            if (ptr_i == I_LAST) begin
                ptr_i        <= '0;
                inter_loaded <= 1'b1;
            end else begin
                ptr_i <= ptr_i + 1'b1;
            end
        end else begin
            ptr_i <= '0;
        end
    end

    // Table storage has no reset; contents are only trusted once the loaded flags are set.
    always_ff @(posedge clk) begin
        if (in_valid_self) begin
            self_tab[ptr_s] <= self_energy_in;
        end
        if (in_valid_interact) begin
            inter_tab[ptr_i] <= interact_energy_in;
        end
    end

    always_comb begin
        cur_code  = shift_reg[PL-1:0];
        nxt_code  = (k == K_LAST) ? first_code : shift_reg[2*PL-1:PL];
        has_bond  = (k != K_LAST) || (PERIODIC != 0);
        cur_ok    = ({1'b0, cur_code} < N_EXT);
        nxt_ok    = ({1'b0, nxt_code} < N_EXT);
        safe_cur  = cur_ok ? SW'(cur_code) : '0;
        safe_nxt  = nxt_ok ? SW'(nxt_code) : '0;
        inter_idx = IW'(safe_cur) * IW'(N) + IW'(safe_nxt);
        self_e    = self_tab[safe_cur];
        bond_e    = has_bond ? inter_tab[inter_idx] : '0;
        step      = {1'b0, self_e} + {1'b0, bond_e};
        sum       = {1'b0, acc} + (FW+1)'(step);
        acc_next  = sum[FW] ? '1 : sum[FW-1:0];
        final_fit = invalid ? '1 : acc;
    end

    // Outputs are registered and default to zero so they read 0 outside their pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_state        <= S_IDLE;
            k                <= '0;
            acc              <= '0;
            invalid          <= 1'b0;
            shift_reg        <= '0;
            first_code       <= '0;
            ind_state        <= '0;
            ind_mut          <= '0;
            ind_last         <= 1'b0;
            best_held        <= 1'b0;
            best_fit         <= '0;
            best_state       <= '0;
            best_mut         <= '0;
            fit_valid        <= 1'b0;
            fit_o            <= '0;
            fit_invalid_o    <= 1'b0;
            best_valid       <= 1'b0;
            Min_fit_o        <= '0;
            Best_ind_state_o <= '0;
            Best_ind_mut_o   <= '0;
        end else begin
            fit_valid        <= 1'b0;
            fit_o            <= '0;
            fit_invalid_o    <= 1'b0;
            best_valid       <= 1'b0;
            Min_fit_o        <= '0;
            Best_ind_state_o <= '0;
            Best_ind_mut_o   <= '0;
            case (fsm_state)
                S_IDLE: begin
                    if (accept) begin
                        ind_state  <= ind_state_in;
                        ind_mut    <= ind_mut_in;
                        ind_last   <= ind_last_in;
                        shift_reg  <= ind_state_in;
                        first_code <= ind_state_in[PL-1:0];
                        acc        <= '0;
                        invalid    <= 1'b0;
                        k          <= '0;
                        fsm_state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    acc       <= acc_next;
                    shift_reg <= shift_reg >> PL;
                    if (!cur_ok) begin
                        invalid <= 1'b1;
                    end
                    if (k == K_LAST) begin
                        fsm_state <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    fit_valid     <= 1'b1;
                    fit_o         <= final_fit;
                    fit_invalid_o <= invalid;
                    // Strict compare: on a tie the earlier individual stays best.
                    if (!best_held || (final_fit < best_fit)) begin
                        best_held  <= 1'b1;
                        best_fit   <= final_fit;
                        best_state <= ind_state;
                        best_mut   <= ind_mut;
                    end
                    fsm_state <= ind_last ? S_BEST : S_IDLE;
                end
                S_BEST: begin
                    best_valid       <= 1'b1;
                    Min_fit_o        <= best_fit;
                    Best_ind_state_o <= best_state;
                    Best_ind_mut_o   <= best_mut;
                    best_held        <= 1'b0;
                    best_fit         <= '0;
                    best_state       <= '0;
                    best_mut         <= '0;
                    fsm_state        <= S_IDLE;
                end
                default: fsm_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lattice_fitness_engine.sv
// Directed bench for lattice_fitness_engine: one open-boundary and one periodic
// instance share the same stimulus and are checked against hand-computed values.
module tb_lattice_fitness_engine;

    logic        clk;
    logic        rst;
    logic        in_valid_self;
    logic [3:0]  self_energy_in;
    logic        in_valid_interact;
    logic [3:0]  interact_energy_in;
    logic        in_valid_ind;
    logic [21:0] ind_state_in;
    logic [7:0]  ind_mut_in;
    logic        ind_last_in;

    logic        in_ready0, fit_valid0, fit_inv0, best_valid0;
    logic [9:0]  fit_o0, min_fit0;
    logic [21:0] best_state0;
    logic [7:0]  best_mut0;
    logic        in_ready1, fit_valid1, fit_inv1, best_valid1;
    logic [9:0]  fit_o1, min_fit1;
    logic [21:0] best_state1;
    logic [7:0]  best_mut1;

    int checks;
    int failures;
    int gate_err;
    int fit_cnt0;
    int best_cnt0;
    int best_cnt1;
    logic [9:0]  cap_min0, cap_min1;
    logic [21:0] cap_state0, cap_state1;
    logic [7:0]  cap_mut0, cap_mut1;

    int          lat;
    logic [9:0]  res_fit0, res_fit1;
    logic        res_inv0, res_inv1;

    lattice_fitness_engine #(.PERIODIC(0)) dut_open (
        .clk(clk), .rst(rst),
        .in_valid_self(in_valid_self), .self_energy_in(self_energy_in),
        .in_valid_interact(in_valid_interact), .interact_energy_in(interact_energy_in),
        .in_valid_ind(in_valid_ind), .ind_state_in(ind_state_in),
        .ind_mut_in(ind_mut_in), .ind_last_in(ind_last_in),
        .in_ready(in_ready0), .fit_valid(fit_valid0), .fit_o(fit_o0),
        .fit_invalid_o(fit_inv0), .best_valid(best_valid0), .Min_fit_o(min_fit0),
        .Best_ind_state_o(best_state0), .Best_ind_mut_o(best_mut0)
    );

    lattice_fitness_engine #(.PERIODIC(1)) dut_ring (
        .clk(clk), .rst(rst),
        .in_valid_self(in_valid_self), .self_energy_in(self_energy_in),
        .in_valid_interact(in_valid_interact), .interact_energy_in(interact_energy_in),
        .in_valid_ind(in_valid_ind), .ind_state_in(ind_state_in),
        .ind_mut_in(ind_mut_in), .ind_last_in(ind_last_in),
        .in_ready(in_ready1), .fit_valid(fit_valid1), .fit_o(fit_o1),
        .fit_invalid_o(fit_inv1), .best_valid(best_valid1), .Min_fit_o(min_fit1),
        .Best_ind_state_o(best_state1), .Best_ind_mut_o(best_mut1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Gating monitor: result fields must read zero outside their pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (fit_valid0) fit_cnt0++;
            else if (fit_o0 !== 10'd0 || fit_inv0 !== 1'b0) gate_err++;
            if (!fit_valid1 && (fit_o1 !== 10'd0 || fit_inv1 !== 1'b0)) gate_err++;
            if (best_valid0) begin
                best_cnt0++;
                cap_min0   = min_fit0;
                cap_state0 = best_state0;
                cap_mut0   = best_mut0;
                if (in_ready0 !== 1'b0) gate_err++;
            end else if (min_fit0 !== 10'd0 || best_state0 !== 22'd0 || best_mut0 !== 8'd0) begin
                gate_err++;
            end
            if (best_valid1) begin
                best_cnt1++;
                cap_min1   = min_fit1;
                cap_state1 = best_state1;
                cap_mut1   = best_mut1;
            end else if (min_fit1 !== 10'd0 || best_state1 !== 22'd0 || best_mut1 !== 8'd0) begin
                gate_err++;
            end
        end
    end

    task automatic loadSelf();
        for (int i = 0; i < 3; i++) begin
            in_valid_self  = 1'b1;
            self_energy_in = 4'(i + 1);
            @(negedge clk);
        end
        in_valid_self = 1'b0;
    endtask

    task automatic loadInter();
        for (int i = 0; i < 9; i++) begin
            in_valid_interact  = 1'b1;
            interact_energy_in = 4'(i);
            @(negedge clk);
        end
        in_valid_interact = 1'b0;
    endtask

    // Offers one individual and waits (bounded) for its fit_valid pulse; lat counts
    // cycles from the accept cycle to the cycle in which fit_valid is seen.
    task automatic applyStimulus(input logic [21:0] st, input logic [7:0] mut, input logic lst);
        int n;
        n = 0;
        while (in_ready0 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_accept", {63'd0, in_ready0}, 64'd1);
        ind_state_in = st;
        ind_mut_in   = mut;
        ind_last_in  = lst;
        in_valid_ind = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid_ind = 1'b0;
            lat++;
        end while (fit_valid0 !== 1'b1 && lat < 40);
        res_fit0 = fit_o0;
        res_inv0 = fit_inv0;
        res_fit1 = fit_o1;
        res_inv1 = fit_inv1;
    endtask

    task automatic checkBest(input string tag, input int cnt, input logic [9:0] min_fit,
                             input logic [21:0] st, input logic [7:0] mut);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_count"}, 64'(best_cnt0), 64'(cnt));
        checkOutput({tag, "_min"}, {54'd0, cap_min0}, {54'd0, min_fit});
        checkOutput({tag, "_state"}, {42'd0, cap_state0}, {42'd0, st});
        checkOutput({tag, "_mut"}, {56'd0, cap_mut0}, {56'd0, mut});
        checkOutput({tag, "_ring_min"}, {54'd0, cap_min1}, {54'd0, min_fit});
        checkOutput({tag, "_ring_mut"}, {56'd0, cap_mut1}, {56'd0, mut});
    endtask

    initial begin
        checks = 0; failures = 0; gate_err = 0;
        fit_cnt0 = 0; best_cnt0 = 0; best_cnt1 = 0;
        cap_min0 = '0; cap_state0 = '0; cap_mut0 = '0;
        cap_min1 = '0; cap_state1 = '0; cap_mut1 = '0;
        rst = 1'b0;
        in_valid_self = 1'b0; self_energy_in = '0;
        in_valid_interact = 1'b0; interact_energy_in = '0;
        in_valid_ind = 1'b0; ind_state_in = '0; ind_mut_in = '0; ind_last_in = 1'b0;

        // Reset asserted between edges must clear outputs without a clock.
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_in_ready", {63'd0, in_ready0}, 64'd0);
        checkOutput("rst_fit_valid", {63'd0, fit_valid0}, 64'd0);
        checkOutput("rst_fit_o", {54'd0, fit_o0}, 64'd0);
        checkOutput("rst_best_valid", {63'd0, best_valid0}, 64'd0);
        checkOutput("rst_min_fit", {54'd0, min_fit0}, 64'd0);
        checkOutput("rst_best_state", {42'd0, best_state0}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_no_tables", {63'd0, in_ready0}, 64'd0);
        loadSelf();
        checkOutput("ready_self_only", {63'd0, in_ready0}, 64'd0);
        loadInter();
        checkOutput("ready_loaded", {63'd0, in_ready0}, 64'd1);
        checkOutput("ready_loaded_ring", {63'd0, in_ready1}, 64'd1);

        $display("[TB] basic evaluation and periodic boundary");
        applyStimulus(22'h2AAAAA, 8'h10, 1'b0);
        checkOutput("latency", 64'(lat), 64'd13);
        checkOutput("all2_fit", {54'd0, res_fit0}, 64'd113);
        checkOutput("all2_invalid", {63'd0, res_inv0}, 64'd0);
        checkOutput("all2_ring_fit", {54'd0, res_fit1}, 64'd121);
        applyStimulus(22'h000000, 8'h20, 1'b1);
        checkOutput("zero_fit", {54'd0, res_fit0}, 64'd11);
        checkOutput("zero_ring_fit", {54'd0, res_fit1}, 64'd11);
        checkBest("pop1", 1, 10'd11, 22'h000000, 8'h20);

        $display("[TB] population best and tie rule");
        applyStimulus(22'h2AAAAA, 8'h01, 1'b0);
        checkOutput("pop2_a_fit", {54'd0, res_fit0}, 64'd113);
        checkOutput("pop2_a_ring_fit", {54'd0, res_fit1}, 64'd121);
        applyStimulus(22'h000000, 8'h02, 1'b0);
        checkOutput("pop2_b_fit", {54'd0, res_fit0}, 64'd11);
        applyStimulus(22'h000000, 8'h03, 1'b1);
        checkOutput("pop2_c_fit", {54'd0, res_fit0}, 64'd11);
        checkBest("pop2", 2, 10'd11, 22'h000000, 8'h02);

        $display("[TB] invalid particle code");
        applyStimulus(22'h000003, 8'h04, 1'b0);
        checkOutput("inv_fit", {54'd0, res_fit0}, 64'h3FF);
        checkOutput("inv_flag", {63'd0, res_inv0}, 64'd1);
        checkOutput("inv_ring_fit", {54'd0, res_fit1}, 64'h3FF);
        checkOutput("inv_ring_flag", {63'd0, res_inv1}, 64'd1);
        applyStimulus(22'h000000, 8'h05, 1'b1);
        checkOutput("pop3_zero_fit", {54'd0, res_fit0}, 64'd11);
        checkOutput("pop3_zero_flag", {63'd0, res_inv0}, 64'd0);
        checkBest("pop3", 3, 10'd11, 22'h000000, 8'h05);

        $display("[TB] reset abort mid-evaluation");
        ind_state_in = 22'h2AAAAA; ind_mut_in = 8'h33; ind_last_in = 1'b1;
        in_valid_ind = 1'b1;
        @(negedge clk);
        in_valid_ind = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_fit_valid", {63'd0, fit_valid0}, 64'd0);
        checkOutput("abort_in_ready", {63'd0, in_ready0}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid_ind = 1'b1;
        repeat (20) @(negedge clk);
        in_valid_ind = 1'b0;
        checkOutput("abort_fit_count", 64'(fit_cnt0), 64'd7);
        checkOutput("abort_best_count", 64'(best_cnt0), 64'd3);
        checkOutput("abort_ready_unloaded", {63'd0, in_ready0}, 64'd0);
        loadSelf();
        loadInter();
        applyStimulus(22'h2AAAAA, 8'h10, 1'b0);
        checkOutput("reload_latency", 64'(lat), 64'd13);
        checkOutput("reload_fit", {54'd0, res_fit0}, 64'd113);
        checkOutput("reload_ring_fit", {54'd0, res_fit1}, 64'd121);

        repeat (4) @(negedge clk);
        checkOutput("total_fit_pulses", 64'(fit_cnt0), 64'd8);
        checkOutput("total_best_pulses", 64'(best_cnt0), 64'd3);
        checkOutput("total_best_pulses_ring", 64'(best_cnt1), 64'd3);
        checkOutput("gating_violations", 64'(gate_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lattice_fitness_engine.md
Name: lattice_fitness_engine

Overview:
- Hardware fitness evaluator and population best-tracker for the lattice-particle evolutionary core.
- Holds self- and interaction-energy tables loaded by stream.
- Evaluates each incoming individual site by site, optionally with a periodic (ring) boundary.
- Reports each individual's fitness, and at population end reports the minimum-fitness individual with its mutation rate.

Parameters:
- INT8_LENGTH, 8, mutation-rate width.
- ENERGY_LENGTH, 4, width of one energy table entry (unsigned).
- PARTICLE_LENGTH, 2, bits per lattice site code.
- LATTICE_LENGTH, 11, sites per individual.
- INDIVIDUAL_LENGTH, PARTICLE_LENGTH*LATTICE_LENGTH, individual state width.
- IND_FIT_LENGTH, 10, fitness width.
- NUM_PARTICLE_TYPE, 3, valid particle codes 0..N-1; N <= 2^PARTICLE_LENGTH.
- PERIODIC, 0, 1 adds the wrap bond between site L-1 and site 0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid_self  in  1  self-energy entry valid.
- self_energy_in  in  ENERGY_LENGTH  self energy, index order 0..N-1.
- in_valid_interact  in  1  interaction entry valid.
- interact_energy_in  in  ENERGY_LENGTH  interaction energy, row-major index i*N+j.
- in_valid_ind  in  1  individual valid.
- ind_state_in  in  INDIVIDUAL_LENGTH  site k at bits [PL*k+PL-1 : PL*k].
- ind_mut_in  in  INT8_LENGTH  individual mutation rate.
- ind_last_in  in  1  marks the last individual of a population.
- in_ready  out  1  individual accepted when in_valid_ind && in_ready.
- fit_valid  out  1  one-cycle pulse per evaluated individual.
- fit_o  out  IND_FIT_LENGTH  fitness of that individual.
- fit_invalid_o  out  1  individual contained a code >= N.
- best_valid  out  1  one-cycle pulse at population end.
- Min_fit_o  out  IND_FIT_LENGTH  population minimum fitness.
- Best_ind_state_o  out  INDIVIDUAL_LENGTH  state of the best individual.
- Best_ind_mut_o  out  INT8_LENGTH  mutation rate of the best individual.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - FSM to IDLE.
  - Table write pointers 0.
  - self_loaded and inter_loaded cleared.
  - Best registers cleared.
  - Table contents need not clear.
- Output gating:
  - fit_o and fit_invalid_o are 0 whenever fit_valid=0.
  - Min_fit_o, Best_ind_state_o and Best_ind_mut_o are 0 whenever best_valid=0.
- Table load:
  - Each in_valid_self cycle writes self[ptr_s]; ptr_s then increments.
  - When ptr_s reaches N-1, self_loaded is set and ptr_s wraps to 0.
  - Any cycle with in_valid_self=0 resets ptr_s to 0.
  - A write at ptr_s=0 clears self_loaded.
  - Interaction table behaves identically with ptr_i over N*N entries and flag inter_loaded.
  - Both tables load concurrently and independently of the individual stream.
- in_ready = (state==IDLE) && self_loaded && inter_loaded.
  - in_valid_ind while in_ready=0 is ignored and the individual is dropped.
- FSM:
  - IDLE -> EVAL on accept. Latch state, mutation rate and last flag; clear accumulator; site counter k=0.
  - EVAL: one site per cycle. acc += self[s_k] + bond_k, where:
    - bond_k = inter[s_k][s_k+1] for k < L-1;
    - for k = L-1, bond_k = inter[s_L-1][s_0] if PERIODIC, else 0.
  - EVAL -> DONE after k = L-1.
  - DONE: fit_valid=1 for one cycle, then best update, then -> IDLE.
- Latency: accept at edge T gives fit_valid high in the cycle after edge T+L+1, i.e. L+2 cycles from accept to fit_valid; back-to-back accept throughput is one individual per L+2 cycles.
- Arithmetic:
  - Unsigned.
  - The accumulator saturates at 2^IND_FIT_LENGTH-1 and never wraps.
  - Any site code >= N makes fit_o = all-ones and fit_invalid_o = 1; table reads for that code are not used.
- Best tracking:
  - In DONE, if no entry is held yet or fit < best_fit (strict), capture fit, state and mutation rate. Ties keep the earlier individual.
  - Invalid individuals participate with fitness all-ones.
- Population end:
  - If the latched last flag is 1, best_valid pulses in the cycle after fit_valid, carrying the updated best; in that cycle in_ready is 0.
  - Best registers then clear for the next population.
- Table reload during EVAL is an upstream protocol violation. The result uses the live table contents and no error is flagged.
- Reset mid-EVAL aborts: no fit_valid and no best_valid. in_ready stays 0 until both tables are fully reloaded.

Test Plan:
1. Reset check: assert rst mid-cycle -> all outputs 0 immediately. in_ready=0 until self={1,2,3} and inter[i][j]=3i+j (values 0..8) are loaded, then in_ready=1.
2. Basic evaluation: with tables from test 1, PERIODIC=0, accept state 22'h2AAAAA (all sites 2), mut 8'h10 -> fit_valid exactly 13 cycles after accept, fit_o=113 (33+80).
3. Periodic boundary: same stimulus with PERIODIC=1 -> fit_o=121. All-zero state -> fit_o=11 in both modes.
4. Population best and tie rule: population {2A AAAA mut 01, 000000 mut 02, 000000 mut 03 with ind_last} -> fit_o 113, 11, 11; best_valid once with Min_fit_o=11, state 0, Best_ind_mut_o=8'h02; all best outputs 0 in every other cycle.
5. Invalid code: state with site0=2'b11, others 0 -> fit_o=10'h3FF, fit_invalid_o=1. In a population together with the all-zero individual, the best is the all-zero one.
6. Reset abort: rst pulse 4 cycles into EVAL -> no fit_valid and no best_valid. in_valid_ind is ignored until both tables are reloaded, after which test 2 passes again.
